// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: opcode constants, hazard FSM state encoding
// and decode helpers used by the hazard/flush control block.
package pipeline_pkg;

  localparam logic [6:0] OP_ADD  = 7'h20;
  localparam logic [6:0] OP_SUB  = 7'h22;
  localparam logic [6:0] OP_ADDU = 7'h21;
  localparam logic [6:0] OP_SUBU = 7'h23;
  localparam logic [6:0] OP_ADDI = 7'h48;
  localparam logic [6:0] OP_AND  = 7'h24;
  localparam logic [6:0] OP_ANDI = 7'h4c;
  localparam logic [6:0] OP_OR   = 7'h25;
  localparam logic [6:0] OP_ORI  = 7'h4d;
  localparam logic [6:0] OP_XOR  = 7'h26;
  localparam logic [6:0] OP_XORI = 7'h4e;
  localparam logic [6:0] OP_NOR  = 7'h27;
  localparam logic [6:0] OP_SLL  = 7'h00;
  localparam logic [6:0] OP_SRL  = 7'h02;
  localparam logic [6:0] OP_LW   = 7'h63;
  localparam logic [6:0] OP_SW   = 7'h6b;
  localparam logic [6:0] OP_BEQ  = 7'h44;
  localparam logic [6:0] OP_BNE  = 7'h45;
  localparam logic [6:0] OP_BLT  = 7'h50;
  localparam logic [6:0] OP_BGE  = 7'h51;
  localparam logic [6:0] OP_J    = 7'h42;
  localparam logic [6:0] OP_JAL  = 7'h43;
  localparam logic [6:0] OP_JR   = 7'h08;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_LU_STALL = 2'd1,
    ST_BR_FLUSH = 2'd2
  } hz_state_t;

  // R-type, stores and conditional branches read rs2; immediates do not.
  function automatic logic uses_rs2(input logic [6:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_ADDU, OP_SUBU, OP_AND, OP_OR, OP_XOR, OP_NOR,
      OP_SLL, OP_SRL, OP_SW, OP_BEQ, OP_BNE, OP_BLT, OP_BGE: uses_rs2 = 1'b1;
      default: uses_rs2 = 1'b0;
    endcase
  endfunction

  function automatic logic is_jump(input logic [6:0] op);
    is_jump = (op == OP_J) || (op == OP_JAL) || (op == OP_JR);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter; holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(negedge clk or posedge rst) begin
    if (rst)                   cnt <= '0;
    else if (inc && cnt != '1) cnt <= cnt + CNT_W'(1);
  end

endmodule

// File: rtl/hazard_flush_ctrl.sv
// Load-use stall and control-flow flush sequencer for the IF/ID and ID/EX
// registers, with saturating perf counters for stall and flush events.
module hazard_flush_ctrl
  import pipeline_pkg::*;
#(
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int BRANCH_PENALTY    = 1,
  parameter int CNT_W             = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       ID_opcode,
  input  logic [4:0]       ID_rs1_ind,
  input  logic [4:0]       ID_rs2_ind,
  input  logic [4:0]       EX_rd_ind,
  input  logic             EX_memread,
  input  logic [6:0]       EX_opcode,
  input  logic             EX_branch_taken,
  output logic             PC_stall,
  output logic             IF_ID_stall,
  output logic             IF_ID_flush,
  output logic             ID_FLUSH,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [3:0] LU_REM = 4'(LOAD_STALL_CYCLES - 1);
  localparam logic [3:0] BR_REM = 4'(BRANCH_PENALTY - 1);

  hz_state_t  state, nstate;
  logic [3:0] rem_cnt, nrem;
  logic       lu_hit, cf_hit;
  logic       stall_inc, flush_inc;
  logic       pc_stall_c, if_id_stall_c, if_id_flush_c, id_flush_c;

  assign lu_hit = EX_memread && (EX_rd_ind != 5'd0) &&
                  ((EX_rd_ind == ID_rs1_ind) ||
                   (uses_rs2(ID_opcode) && (EX_rd_ind == ID_rs2_ind)));
  assign cf_hit = EX_branch_taken || is_jump(EX_opcode);

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_RUN;
      rem_cnt <= 4'd0;
    end else begin
      state   <= nstate;
      rem_cnt <= nrem;
    end
  end

  always_comb begin
    nstate        = state;
    nrem          = rem_cnt;
    pc_stall_c    = 1'b0;
    if_id_stall_c = 1'b0;
    if_id_flush_c = 1'b0;
    id_flush_c    = 1'b0;
    stall_inc     = 1'b0;
    flush_inc     = 1'b0;
    case (state)
      ST_RUN: begin
        // A taken redirect makes the ID instruction wrong-path, so it wins.
        if (cf_hit) begin
          if_id_flush_c = 1'b1;
          id_flush_c    = 1'b1;
          flush_inc     = 1'b1;
          if (BRANCH_PENALTY > 1) begin
            nstate = ST_BR_FLUSH;
            nrem   = BR_REM;
          end
        end else if (lu_hit) begin
          pc_stall_c    = 1'b1;
          if_id_stall_c = 1'b1;
          id_flush_c    = 1'b1;
          stall_inc     = 1'b1;
          if (LOAD_STALL_CYCLES > 1) begin
            nstate = ST_LU_STALL;
            nrem   = LU_REM;
          end
        end
      end
      ST_LU_STALL: begin
        pc_stall_c    = 1'b1;
        if_id_stall_c = 1'b1;
        id_flush_c    = 1'b1;
        nrem          = rem_cnt - 4'd1;
        if (rem_cnt <= 4'd1) begin
          nstate = ST_RUN;
          nrem   = 4'd0;
        end
      end
      ST_BR_FLUSH: begin
        if_id_flush_c = 1'b1;
        id_flush_c    = 1'b1;
        if (cf_hit) begin
          nrem      = BR_REM;
          flush_inc = 1'b1;
        end else begin
          nrem = rem_cnt - 4'd1;
          if (rem_cnt <= 4'd1) begin
            nstate = ST_RUN;
            nrem   = 4'd0;
          end
        end
      end
      default: begin
        nstate = ST_RUN;
        nrem   = 4'd0;
      end
    endcase
  end

  // Controls must drop immediately on reset, even mid-window.
  assign PC_stall    = pc_stall_c    && !rst;
  assign IF_ID_stall = if_id_stall_c && !rst;
  assign IF_ID_flush = if_id_flush_c && !rst;
  assign ID_FLUSH    = id_flush_c    && !rst;

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (stall_inc),
    .cnt (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk (clk),
    .rst (rst),
    .inc (flush_inc),
    .cnt (flush_cnt)
  );

endmodule

// File: tb/tb_hazard_flush_ctrl.sv
// Directed bench: a default instance (a_*) and a long-window, 4-bit-counter
// instance (b_*) share one input stream.
module tb_hazard_flush_ctrl;
  import pipeline_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] ID_opcode, EX_opcode;
  logic [4:0] ID_rs1_ind, ID_rs2_ind, EX_rd_ind;
  logic       EX_memread, EX_branch_taken;

  logic        a_pc_stall, a_ifid_stall, a_ifid_flush, a_id_flush;
  logic [31:0] a_stall_cnt, a_flush_cnt;
  logic        b_pc_stall, b_ifid_stall, b_ifid_flush, b_id_flush;
  logic [3:0]  b_stall_cnt, b_flush_cnt;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  hazard_flush_ctrl u_a (
    .clk(clk), .rst(rst), .ID_opcode(ID_opcode), .ID_rs1_ind(ID_rs1_ind),
    .ID_rs2_ind(ID_rs2_ind), .EX_rd_ind(EX_rd_ind), .EX_memread(EX_memread),
    .EX_opcode(EX_opcode), .EX_branch_taken(EX_branch_taken),
    .PC_stall(a_pc_stall), .IF_ID_stall(a_ifid_stall), .IF_ID_flush(a_ifid_flush),
    .ID_FLUSH(a_id_flush), .stall_cnt(a_stall_cnt), .flush_cnt(a_flush_cnt)
  );

  hazard_flush_ctrl #(.LOAD_STALL_CYCLES(3), .BRANCH_PENALTY(2), .CNT_W(4)) u_b (
    .clk(clk), .rst(rst), .ID_opcode(ID_opcode), .ID_rs1_ind(ID_rs1_ind),
    .ID_rs2_ind(ID_rs2_ind), .EX_rd_ind(EX_rd_ind), .EX_memread(EX_memread),
    .EX_opcode(EX_opcode), .EX_branch_taken(EX_branch_taken),
    .PC_stall(b_pc_stall), .IF_ID_stall(b_ifid_stall), .IF_ID_flush(b_ifid_flush),
    .ID_FLUSH(b_id_flush), .stall_cnt(b_stall_cnt), .flush_cnt(b_flush_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change just after the negedge that consumed the previous set;
  // combinational controls are sampled 2ns later, well clear of the edge.
  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    ID_opcode = OP_ADDI; ID_rs1_ind = 5'd0; ID_rs2_ind = 5'd0;
    EX_opcode = OP_ADDI; EX_rd_ind = 5'd0; EX_memread = 1'b0; EX_branch_taken = 1'b0;
  endtask

  task automatic load_use(input logic [4:0] rd, input logic [6:0] id_op,
                          input logic [4:0] rs1, input logic [4:0] rs2);
    EX_opcode = OP_LW; EX_memread = 1'b1; EX_rd_ind = rd; EX_branch_taken = 1'b0;
    ID_opcode = id_op; ID_rs1_ind = rs1; ID_rs2_ind = rs2;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    #3;
    chk("rst_a_ctrl", {a_pc_stall, a_ifid_stall, a_ifid_flush, a_id_flush}, 4'b0000);
    chk("rst_a_cnt",  a_stall_cnt | a_flush_cnt, 0);
    chk("rst_b_cnt",  {b_stall_cnt, b_flush_cnt}, 0);

    cyc(); rst = 1'b0; idle(); #2;
    chk("idle_a_ctrl", {a_pc_stall, a_ifid_stall, a_ifid_flush, a_id_flush}, 4'b0000);

    // Basic load-use on rs1
    cyc(); load_use(5'd5, OP_ADD, 5'd5, 5'd9); #2;
    chk("lu_a_ctrl", {a_pc_stall, a_ifid_stall, a_ifid_flush, a_id_flush}, 4'b1101);
    chk("lu_b_idf0", b_id_flush, 1);
    cyc(); idle(); #2;
    chk("lu_a_release", {a_pc_stall, a_ifid_stall, a_id_flush}, 3'b000);
    chk("lu_a_cnt", a_stall_cnt, 1);
    chk("lu_b_idf1", b_id_flush, 1);
    chk("lu_b_cnt", b_stall_cnt, 1);
    cyc(); idle(); #2;
    chk("lu_b_idf2", b_id_flush, 1);
    cyc(); idle(); #2;
    chk("lu_b_idf3", b_id_flush, 0);

    // rd = x0 is never a hazard
    cyc(); load_use(5'd0, OP_ADD, 5'd0, 5'd0); #2;
    chk("x0_a_stall", a_pc_stall, 0);
    chk("x0_b_stall", b_pc_stall, 0);
    cyc(); idle(); #2;
    chk("x0_a_cnt", a_stall_cnt, 1);

    // rs2 matters only when the ID opcode reads it
    cyc(); load_use(5'd7, OP_ADDI, 5'd1, 5'd7); #2;
    chk("rs2_addi_stall", a_pc_stall, 0);
    cyc(); load_use(5'd7, OP_SW, 5'd1, 5'd7); #2;
    chk("rs2_sw_a_stall", a_pc_stall, 1);
    chk("rs2_sw_b_ifs", b_ifid_stall, 1);
    cyc(); idle(); #2;
    chk("rs2_sw_a_rel", a_pc_stall, 0);
    chk("rs2_a_cnt", a_stall_cnt, 2);
    chk("rs2_b_cnt", b_stall_cnt, 2);
    cyc(); idle();
    cyc(); idle(); #2;
    chk("rs2_b_drain", b_pc_stall, 0);

    // Taken branch: one flush cycle on a, two on b
    cyc(); idle(); EX_opcode = OP_BEQ; EX_branch_taken = 1'b1; #2;
    chk("br_a_ctrl", {a_pc_stall, a_ifid_stall, a_ifid_flush, a_id_flush}, 4'b0011);
    chk("br_b_iff0", b_ifid_flush, 1);
    cyc(); idle(); #2;
    chk("br_a_iff1", a_ifid_flush, 0);
    chk("br_b_ctrl1", {b_pc_stall, b_ifid_flush, b_id_flush}, 3'b011);
    chk("br_a_cnt", a_flush_cnt, 1);
    chk("br_b_cnt", b_flush_cnt, 1);
    cyc(); idle(); #2;
    chk("br_b_iff2", b_ifid_flush, 0);

    // Jump wins over a simultaneous load-use hazard
    cyc(); load_use(5'd5, OP_ADD, 5'd5, 5'd0); EX_opcode = OP_JR; #2;
    chk("pri_a_ctrl", {a_pc_stall, a_ifid_stall, a_ifid_flush, a_id_flush}, 4'b0011);
    cyc(); idle(); #2;
    chk("pri_a_fcnt", a_flush_cnt, 2);
    chk("pri_a_scnt", a_stall_cnt, 2);
    chk("pri_b_scnt", b_stall_cnt, 2);
    cyc(); idle();

    // Back-to-back jumps re-arm b's flush window
    cyc(); idle(); EX_opcode = OP_JAL; #2;
    chk("rearm_b_iff0", b_ifid_flush, 1);
    cyc(); idle(); EX_opcode = OP_JAL; #2;
    chk("rearm_ab_iff1", {a_ifid_flush, b_ifid_flush}, 2'b11);
    cyc(); idle(); #2;
    chk("rearm_ab_iff2", {a_ifid_flush, b_ifid_flush}, 2'b01);
    cyc(); idle(); #2;
    chk("rearm_b_iff3", b_ifid_flush, 0);
    chk("rearm_a_cnt", a_flush_cnt, 4);
    chk("rearm_b_cnt", b_flush_cnt, 4);

    // Reset during the second cycle of b's load-use window
    cyc(); load_use(5'd5, OP_ADD, 5'd5, 5'd0); #2;
    chk("mid_b_idf0", b_id_flush, 1);
    cyc(); idle(); #2;
    chk("mid_b_idf1", b_id_flush, 1);
    #1 rst = 1'b1;
    #1;
    chk("mid_b_ctrl", {b_pc_stall, b_ifid_stall, b_ifid_flush, b_id_flush}, 4'b0000);
    chk("mid_b_cnt", {b_stall_cnt, b_flush_cnt}, 0);
    chk("mid_a_cnt", a_stall_cnt | a_flush_cnt, 0);
    cyc(); rst = 1'b0; idle(); #2;
    chk("post_b_ctrl", {b_pc_stall, b_ifid_stall, b_id_flush}, 3'b000);

    // 20 flush events saturate the 4-bit counter at 15
    for (int i = 0; i < 20; i++) begin
      cyc(); idle(); EX_opcode = OP_J;
    end
    cyc(); idle();
    cyc(); idle(); #2;
    chk("sat_b_fcnt", b_flush_cnt, 15);
    chk("sat_a_fcnt", a_flush_cnt, 20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/hazard_flush_ctrl.md
Name: hazard_flush_ctrl

Overview:
- Control-side counterpart of the ID/EX pipeline register: the ID/EX register consumes ID_FLUSH; this block produces it, together with the PC and IF/ID stall and flush controls.
- Detects load-use hazards between EX and ID, and taken branches or jumps resolved in EX.
- Sequences multi-cycle stall and flush windows with a small FSM.
- Keeps saturating stall and flush event counters for performance debug.

Parameters:
- LOAD_STALL_CYCLES, 1, bubbles inserted per load-use hazard (1..15).
- BRANCH_PENALTY, 1, cycles ID_FLUSH/IF_ID_flush held after a taken branch or jump (1..15).
- CNT_W, 32, width of the performance counters.

Ports:
- clk  in  1  clock; state updates on negedge, aligned with the pipeline buffers.
- rst  in  1  reset, asynchronous, active-high.
- ID_opcode  in  7  opcode of the instruction in ID.
- ID_rs1_ind  in  5  rs1 index in ID.
- ID_rs2_ind  in  5  rs2 index in ID.
- EX_rd_ind  in  5  destination index in EX.
- EX_memread  in  1  the instruction in EX is a load.
- EX_opcode  in  7  opcode in EX.
- EX_branch_taken  in  1  a conditional branch in EX resolved taken.
- PC_stall  out  1  hold the PC.
- IF_ID_stall  out  1  hold the IF/ID register.
- IF_ID_flush  out  1  zero the IF/ID register.
- ID_FLUSH  out  1  zero the ID/EX register (bubble).
- stall_cnt  out  CNT_W  load-use hazard events.
- flush_cnt  out  CNT_W  control-flow flush events.

Behaviour:
- States: RUN, LU_STALL, BR_FLUSH. A 4-bit down-counter rem_cnt holds the remaining cycles of a window.
- Control outputs are combinational from the registered state and the current inputs, so the negedge-sampling buffers see them in the same cycle. Counters are registered.

Hazard detection:
- rs2 is used for R-type opcodes, sw, beq, bne, blt and bge.
- lu_hit = EX_memread & (EX_rd_ind != 0) & ((EX_rd_ind == ID_rs1_ind) | (rs2 used & EX_rd_ind == ID_rs2_ind)).
- cf_hit = EX_branch_taken | EX_opcode in {j, jal, jr}.

RUN:
- If cf_hit:
  - Drive IF_ID_flush=1 and ID_FLUSH=1; PC_stall=0 so the redirect target loads.
  - flush_cnt increments.
  - If BRANCH_PENALTY > 1: go to BR_FLUSH with rem_cnt = BRANCH_PENALTY-1.
- Else if lu_hit:
  - Drive PC_stall=1, IF_ID_stall=1, ID_FLUSH=1.
  - stall_cnt increments.
  - If LOAD_STALL_CYCLES > 1: go to LU_STALL with rem_cnt = LOAD_STALL_CYCLES-1.
- Else all control outputs are 0.
- cf_hit has priority over lu_hit: the instruction in ID is wrong-path and no stall is counted.

LU_STALL:
- Hold PC_stall=1, IF_ID_stall=1, ID_FLUSH=1.
- Decrement rem_cnt; return to RUN when it reaches 0.
- cf_hit cannot occur here, because EX holds a bubble.

BR_FLUSH:
- Hold IF_ID_flush=1 and ID_FLUSH=1.
- Decrement rem_cnt; return to RUN when it reaches 0.
- A new cf_hit re-arms rem_cnt = BRANCH_PENALTY-1 and increments flush_cnt.

Counters:
- Saturate at all-ones and never wrap.

Reset:
- rst asynchronously forces state RUN, rem_cnt=0 and both counters to 0.
- All control outputs read 0 during reset, including reset asserted mid-window.
- After rst deasserts, the first negedge evaluates fresh inputs.

Decomposition:
- Shared package pipeline_pkg:
  - 7-bit opcode constants: add 0x20, sub 0x22, addu 0x21, subu 0x23, addi 0x48, and 0x24, andi 0x4c, or 0x25, ori 0x4d, xor 0x26, xori 0x4e, nor 0x27, sll 0x00, srl 0x02, lw 0x63, sw 0x6b, beq 0x44, bne 0x45, blt 0x50, bge 0x51, j 0x42, jal 0x43, jr 0x08.
  - State encoding.
  - uses_rs2() function.
- One sub-module, sat_counter (CNT_W, inc, rst), instantiated twice for stall_cnt and flush_cnt.

Test Plan:
- Load-use hit: EX lw with rd=5, ID add rs1=5, defaults. Required: PC_stall, IF_ID_stall and ID_FLUSH all 1 for exactly one cycle; stall_cnt=1.
- Load with rd=0: EX lw rd=0, ID rs1=0. Required: no stall; stall_cnt stays 0.
- rs2 only when used: ID addi with rs2 field equal to the load rd. Required: no stall. Repeat with ID sw. Required: one stall.
- Multi-cycle windows: LOAD_STALL_CYCLES=3 with a hazard. Required: ID_FLUSH high for 3 consecutive cycles, stall_cnt=1. BRANCH_PENALTY=2 with a taken beq. Required: IF_ID_flush high for 2 cycles.
- Priority: EX jr and lu_hit presented together. Required: IF_ID_flush=1, PC_stall=0, flush_cnt=1, stall_cnt=0.
- Reset mid-window: rst pulsed during the second LU_STALL cycle. Required: outputs 0 immediately and counters 0. Then force CNT_W=4 and apply 20 flushes. Required: flush_cnt holds at 15.
